// File: rtl/sample_ram_pkg.sv
// Shared types and default constants for the sample RAM controller.
package sample_ram_pkg;

    localparam int unsigned ADDR_W_DEF     = 11;
    localparam int unsigned DATA_W_DEF     = 9;
    localparam int unsigned MAX_STREAK_DEF = 4;
    localparam logic [DATA_W_DEF-1:0] CLR_VALUE_DEF = 9'h15A;

    // Controller mode: normal arbitration or full-memory clear sweep.
    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/sample_ram_prio.sv
// Write/read arbiter with a bounded write streak so a pending read cannot starve.
module sample_ram_prio #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wr_req,
    input  logic i_rd_req,
    input  logic i_enable,
    output logic o_wr_gnt,
    output logic o_rd_gnt
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                w_streak_full;

    // Grant decision: writes win until the streak limit, then one read goes through.
    always_comb begin
        w_streak_full = (r_streak == STREAK_MAX);
        o_wr_gnt      = i_enable & i_wr_req & (~i_rd_req | ~w_streak_full);
        o_rd_gnt      = i_enable & i_rd_req & ~o_wr_gnt;
    end

    // Streak counts writes granted over a waiting read; cleared when no read waits.
    always_comb begin
        w_streak_nxt = r_streak;
        if (!i_rd_req || o_rd_gnt) begin
            w_streak_nxt = '0;
        end else if (o_wr_gnt) begin
            w_streak_nxt = r_streak + STREAK_W'(1);
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_nxt;
        end
    end

endmodule

// File: rtl/sample_ram_ctrl.sv
// Owns the single-port sample RAM: arbitrates capture writes vs readback reads
// and runs a full-memory clear sweep on command.
module sample_ram_ctrl
    import sample_ram_pkg::*;
#(
    parameter int unsigned          ADDR_W     = ADDR_W_DEF,
    parameter int unsigned          DATA_W     = DATA_W_DEF,
    parameter int unsigned          MAX_STREAK = MAX_STREAK_DEF,
    parameter logic [DATA_W-1:0]    CLR_VALUE  = DATA_W'(CLR_VALUE_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_sweep_cnt;
    logic                w_sweep_last;
    logic                w_wr_gnt;
    logic                w_rd_gnt;
    logic                w_arb_en;
    logic                w_ram_en;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_di;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_di;
    logic                r_rd_valid;
    logic                r_clr_done;

    assign w_arb_en = (r_state == RUN);

    sample_ram_prio #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_req (wr_req),
        .i_rd_req (rd_req),
        .i_enable (w_arb_en),
        .o_wr_gnt (w_wr_gnt),
        .o_rd_gnt (w_rd_gnt)
    );

    // Next state and RAM pin mux; address/data hold their last driven value when idle.
    always_comb begin
        w_state_nxt  = r_state;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_ram_addr;
        w_ram_di     = r_ram_di;
        w_sweep_last = 1'b0;
        case (r_state)
            RUN: begin
                if (w_wr_gnt) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = 1'b1;
                    w_ram_addr = wr_addr;
                    w_ram_di   = wr_data;
                end else if (w_rd_gnt) begin
                    w_ram_en   = 1'b1;
                    w_ram_addr = rd_addr;
                end else if (clr) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_ram_en     = 1'b1;
                w_ram_we     = 1'b1;
                w_ram_addr   = r_sweep_cnt;
                w_ram_di     = CLR_VALUE;
                w_sweep_last = (r_sweep_cnt == '1);
                if (w_sweep_last) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep address counter; natural wrap back to zero ends the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_sweep_cnt <= r_sweep_cnt + ADDR_W'(1);
        end else begin
            r_sweep_cnt <= '0;
        end
    end

    // Hold registers for RAM address/data across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr <= '0;
            r_ram_di   <= '0;
        end else if (w_ram_en) begin
            r_ram_addr <= w_ram_addr;
            r_ram_di   <= w_ram_di;
        end
    end

    // Read-valid pipeline and end-of-sweep pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_gnt;
            r_clr_done <= w_sweep_last;
        end
    end

    assign wr_ack   = w_wr_gnt;
    assign rd_ack   = w_rd_gnt;
    assign ram_en   = w_ram_en;
    assign ram_we   = w_ram_we;
    assign ram_addr = w_ram_addr;
    assign ram_di   = w_ram_di;
    assign clr_busy = (r_state == CLEAR);
    assign clr_done = r_clr_done;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_valid ? ram_do : '0;

endmodule

// File: tb/tb_sample_ram_ctrl.sv
// Self-checking bench for sample_ram_ctrl: RAM primitive model, cycle-level
// behavioural model with per-cycle compare, and directed literal checks.
module tb_sample_ram_ctrl;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 9;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned MAXS  = 4;
    localparam logic [DW-1:0] CLRV = 9'h15A;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          clr_busy;
    logic          clr_done;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    int n_checks = 0;
    int n_fail   = 0;

    sample_ram_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port RAM primitive with registered read data.
    logic [DW-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_do = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_do <= mem[ram_addr];
        end
    end

    // Behavioural model: expected memory image and controller mode.
    logic [DW-1:0] sm [0:DEPTH-1];
    bit            m_clear, m_rv, m_done;
    int            m_pos, m_streak;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_di, m_word;
    bit            e_wa, e_ra, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di;

    initial begin
        for (int i = 0; i < DEPTH; i++) sm[i] = '0;
    end

    // Per-cycle compare against the model, then advance the model one clock.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("m_rst_ctl", {wr_ack, rd_ack, rd_valid, clr_busy, clr_done, ram_en, ram_we}, 0);
            check("m_rst_addr", ram_addr, 0);
            check("m_rst_di", ram_di, 0);
            m_clear = 0; m_rv = 0; m_done = 0; m_pos = 0; m_streak = 0;
            m_addr = '0; m_di = '0; m_word = '0;
        end else begin
            if (m_clear) begin
                e_wa = 0; e_ra = 0; e_en = 1; e_we = 1;
                e_addr = AW'(m_pos); e_di = CLRV;
            end else begin
                e_wa   = wr_req && (!rd_req || m_streak < MAXS);
                e_ra   = rd_req && !e_wa;
                e_en   = e_wa || e_ra;
                e_we   = e_wa;
                e_addr = e_wa ? wr_addr : (e_ra ? rd_addr : m_addr);
                e_di   = e_wa ? wr_data : m_di;
            end
            check("m_wr_ack", wr_ack, e_wa);
            check("m_rd_ack", rd_ack, e_ra);
            check("m_ram_en", ram_en, e_en);
            check("m_ram_we", ram_we, e_we);
            check("m_ram_addr", ram_addr, e_addr);
            check("m_ram_di", ram_di, e_di);
            check("m_clr_busy", clr_busy, m_clear);
            check("m_clr_done", clr_done, m_done);
            check("m_rd_valid", rd_valid, m_rv);
            if (m_rv) check("m_rd_data", rd_data, m_word);

            if (e_en) begin m_addr = e_addr; m_di = e_di; end
            if (e_ra) m_word = sm[rd_addr];
            if (e_we) sm[e_addr] = e_di;
            m_rv   = e_ra;
            m_done = m_clear && (m_pos == DEPTH - 1);
            if (!rd_req || e_ra) m_streak = 0;
            else if (e_wa)       m_streak = m_streak + 1;
            if (m_clear) begin
                if (m_pos == DEPTH - 1) m_clear = 0;
                else                    m_pos = m_pos + 1;
            end else if (clr && !e_en) begin
                m_clear = 1;
                m_pos   = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        step();
        rd_req = 1'b1; rd_addr = a;
        sample();
        check({name, "_ack"}, rd_ack, 1);
        step();
        rd_req = 1'b0;
        sample();
        check({name, "_valid"}, rd_valid, 1);
        check({name, "_data"}, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] rd_pat, wr_pat;
    int  busy_cnt, done_cnt, early_ack, reads10;
    bit  got_done, ack_at_done, busy_at_done, found;

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) sample();
        check("reset_ctl", {wr_ack, rd_ack, rd_valid, clr_busy, clr_done, ram_en, ram_we}, 0);
        check("reset_addr_di", {ram_addr, ram_di}, 0);
        check("reset_rd_data", rd_data, 0);

        step(); rst_n = 1'b1;
        sample();
        check("idle_en", {ram_en, ram_we, wr_ack, rd_ack}, 0);

        // First write: same-cycle grant
        step(); wr_req = 1'b1; wr_addr = 11'h005; wr_data = 9'h0A3;
        sample();
        check("w5_ack", wr_ack, 1);
        check("w5_we", ram_we, 1);
        check("w5_addr", ram_addr, 11'h005);
        check("w5_di", ram_di, 9'h0A3);

        // Write top address then read it back
        step(); wr_addr = 11'h7FF; wr_data = 9'h1FF;
        sample();
        check("w7ff_ack", wr_ack, 1);
        step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'h7FF;
        sample();
        check("r7ff_ack", rd_ack, 1);
        check("r7ff_we", ram_we, 0);
        check("r7ff_addr", ram_addr, 11'h7FF);
        step(); rd_req = 1'b0;
        sample();
        check("r7ff_valid", rd_valid, 1);
        check("r7ff_data", rd_data, 9'h1FF);

        // Both requesters held: W,W,W,W,R repeating
        step(); wr_req = 1'b1; rd_req = 1'b1; wr_addr = 11'h010; wr_data = 9'h100; rd_addr = 11'h7FF;
        reads10 = 0;
        for (int i = 0; i < 12; i++) begin
            sample();
            rd_pat[i] = rd_ack;
            wr_pat[i] = wr_ack;
            if (i < 10 && rd_ack) reads10++;
            if (i < 11) begin
                step();
                wr_data = wr_data + 9'd1;
            end
        end
        check("arb_rd_pattern", rd_pat, 12'h210);
        check("arb_wr_pattern", wr_pat, 12'hDEF);
        check("arb_reads_in_10", reads10, 2);
        step(); wr_req = 1'b0; rd_req = 1'b0;
        sample();

        // Clear sweep with a write arriving mid-sweep
        step(); clr = 1'b1;
        sample();
        check("clr_cycle_busy", clr_busy, 0);
        step(); clr = 1'b0;
        busy_cnt = 0; early_ack = 0; got_done = 0; ack_at_done = 0; busy_at_done = 1;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            sample();
            if (clr_done) begin
                got_done = 1; ack_at_done = wr_ack; busy_at_done = clr_busy;
            end else begin
                if (clr_busy) busy_cnt++;
                if (wr_ack) early_ack++;
                step();
                if (busy_cnt == 100) begin
                    wr_req = 1'b1; wr_addr = 11'h123; wr_data = 9'h0AA;
                end
            end
        end
        check("sweep_done_seen", got_done, 1);
        check("sweep_busy_cycles", busy_cnt, 2048);
        check("sweep_no_early_ack", early_ack, 0);
        check("sweep_ack_at_done", ack_at_done, 1);
        check("sweep_busy_at_done", busy_at_done, 0);
        done_cnt = got_done ? 1 : 0;
        step(); wr_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (clr_done) done_cnt++;
            step();
        end
        check("sweep_done_single", done_cnt, 1);

        do_read("rd000", 11'h000, 9'h15A);
        do_read("rd400", 11'h400, 9'h15A);
        do_read("rd7ff", 11'h7FF, 9'h15A);

        // clr together with a write: write wins, sweep follows
        step(); clr = 1'b1; wr_req = 1'b1; wr_addr = 11'h055; wr_data = 9'h033;
        sample();
        check("cw_wr_ack", wr_ack, 1);
        check("cw_busy0", clr_busy, 0);
        step(); wr_req = 1'b0;
        sample();
        check("cw_nogrant_busy", clr_busy, 0);
        step();
        sample();
        check("cw_sweep_busy", clr_busy, 1);
        check("cw_sweep_addr", ram_addr, 11'h000);
        check("cw_sweep_di", ram_di, 9'h15A);
        step(); clr = 1'b0;

        // Abort the sweep with reset at address 0x300
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            sample();
            if (clr_busy && ram_addr == 11'h300) found = 1;
            else step();
        end
        check("abort_addr_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_ctl", {wr_ack, rd_ack, rd_valid, clr_busy, clr_done, ram_en, ram_we}, 0);
        check("abort_async_addr_di", {ram_addr, ram_di}, 0);
        repeat (2) sample();
        step(); rst_n = 1'b1; wr_req = 1'b1; wr_addr = 11'h200; wr_data = 9'h011;
        sample();
        check("post_rst_wr_ack", wr_ack, 1);
        check("post_rst_addr", ram_addr, 11'h200);
        check("post_rst_busy", clr_busy, 0);
        step(); wr_req = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (clr_done) done_cnt++;
            step();
        end
        check("post_rst_no_done", done_cnt, 0);

        do_read("rd200", 11'h200, 9'h011);
        do_read("rd005", 11'h005, 9'h15A);
        do_read("rd055", 11'h055, 9'h15A);
        do_read("rd7ff_b", 11'h7FF, 9'h15A);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
